// File: rtl/alu_seq_md.sv
// Sequential RV32I/RV32M execute unit: single-cycle basic ops plus a radix-2
// iterative multiply/divide engine, valid/ready on both sides, result held until taken.
module alu_seq_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [4:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLT   = 5'd5;
  localparam logic [4:0] OP_SLTU  = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_MUL   = 5'd10;
  localparam logic [4:0] OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_REM   = 5'd15;
  localparam logic [4:0] OP_REMU  = 5'd16;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  logic [SHW:0]     cnt_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] mag_b_q;
  logic [WIDTH-1:0] src_a_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic             neg_q;
  logic             neg_rem_q;
  logic             div0_q;

  logic             accept;
  logic             last_step;
  logic             is_md_in;
  logic             signed_in;
  logic             sa_in;
  logic             sb_in;
  logic             is_div_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n;
  logic [WIDTH-1:0]   mul_lo_n;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi_n;
  logic [WIDTH-1:0]   div_lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   md_res;
  logic [WIDTH-1:0]   basic_res;

  function automatic logic [WIDTH-1:0] basic_op(input logic [4:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    r  = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = (sa < sb) ? WIDTH'(1) : '0;
      OP_SLTU: r = (a < b) ? WIDTH'(1) : '0;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = sa >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] x,
                                                       input logic neg);
    return neg ? -x : x;
  endfunction

  assign accept    = in_valid && (state_q == IDLE);
  assign last_step = (cnt_q == CNT_LAST);
  assign is_md_in  = (ALUControl >= OP_MUL) && (ALUControl <= OP_REMU);
  // Only MULH, DIV and REM interpret their operands as two's complement.
  assign signed_in = (ALUControl == OP_MULH) || (ALUControl == OP_DIV) ||
                     (ALUControl == OP_REM);
  assign sa_in     = signed_in && srcA[WIDTH-1];
  assign sb_in     = signed_in && srcB[WIDTH-1];
  assign is_div_q  = (op_q >= OP_DIV);
  assign basic_res = basic_op(ALUControl, srcA, srcB);

  // Iteration step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, mag_b_q});
    div_hi_n = div_ge ? (div_sh[WIDTH-1:0] - mag_b_q) : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo_q[WIDTH-2:0], div_ge};
  end

  // Result fix-up on the final step: sign restore and divide-by-zero override
  always_comb begin
    prod = cond_neg_wide({mul_hi_n, mul_lo_n}, neg_q);
    quo  = div0_q ? '1 : cond_neg(div_lo_n, neg_q);
    rmd  = div0_q ? src_a_q : cond_neg(div_hi_n, neg_rem_q);
    case (op_q)
      OP_MUL:            md_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHU: md_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:   md_res = quo;
      OP_REM, OP_REMU:   md_res = rmd;
      default:           md_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_md_in ? BUSY : DONE;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res     <= '0;
      zero    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && is_md_in) begin
        cnt_q <= CNT_INIT;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CNT_LAST;
      end
      if (accept && !is_md_in) begin
        res  <= basic_res;
        zero <= (basic_res == '0);
      end else if ((state_q == BUSY) && last_step) begin
        res  <= md_res;
        zero <= (md_res == '0);
      end
    end
  end

  // Engine operands: acc_lo starts as |A| (multiplier / dividend), acc_hi accumulates
  always_ff @(posedge clk) begin
    if (accept && is_md_in) begin
      op_q      <= ALUControl;
      mag_b_q   <= cond_neg(srcB, sb_in);
      src_a_q   <= srcA;
      div0_q    <= (srcB == '0);
      neg_q     <= sa_in ^ sb_in;
      neg_rem_q <= sa_in;
      acc_hi_q  <= '0;
      acc_lo_q  <= cond_neg(srcA, sa_in);
    end else if (state_q == BUSY) begin
      acc_hi_q <= is_div_q ? div_hi_n : mul_hi_n;
      acc_lo_q <= is_div_q ? div_lo_n : mul_lo_n;
    end
  end

endmodule

// File: tb/tb_alu_seq_md.sv
// Bench for alu_seq_md: directed corner cases plus random ops checked
// against an arithmetic reference model of the RV32IM semantics.
module tb_alu_seq_md;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [4:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        zero;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq_md #(.WIDTH(32), .SHW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .srcA       (srcA),
    .srcB       (srcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res        (res),
    .zero       (zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up, ua, ub;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    up = ua * ub;
    sp = sa * sb;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd6:  r = (a < b) ? 32'd1 : 32'd0;
      5'd7:  r = a << b[4:0];
      5'd8:  r = a >> b[4:0];
      5'd9:  r = $signed(a) >>> b[4:0];
      5'd10: r = up[31:0];
      5'd11: r = sp[63:32];
      5'd12: r = up[63:32];
      5'd13: r = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
      5'd14: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd15: r = (b == 0) ? a : 32'(sa % sb);
      5'd16: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble inputs while it is in flight, hold DONE for `hold` cycles, drain.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    logic [31:0] exp;
    int          lat;
    int          exp_lat;
    bit          md;
    exp     = ref_op(op, a, b);
    md      = (op >= 5'd10) && (op <= 5'd16);
    exp_lat = md ? 33 : 1;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    srcA       = a;
    srcB       = b;
    ALUControl = op;
    @(posedge clk);
    #1;
    in_valid   = 1'($urandom);
    srcA       = $urandom;
    srcB       = $urandom;
    ALUControl = 5'($urandom);
    lat = 1;
    if (md) check_eq({tag, ".busy"}, {30'd0, busy, in_ready}, 32'd2);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      srcA = $urandom;
      lat++;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".res"}, res, exp);
    check_eq({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      srcB     = $urandom;
      check_eq({tag, ".hold"}, {29'd0, out_valid, in_ready, busy}, 32'd4);
      check_eq({tag, ".hold_res"}, res, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ".drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    srcA       = '0;
    srcB       = '0;
    ALUControl = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("reset.ctl", {28'd0, in_ready, out_valid, busy, zero}, 32'h8);
    check_eq("reset.res", res, 32'd0);

    do_op(5'd0,  32'hFFFFFFFF, 32'h00000001, 0, "add_wrap");
    do_op(5'd9,  32'h80000000, 32'h00000004, 0, "sra");
    do_op(5'd11, 32'hFFFFFFFF, 32'h00000002, 0, "mulh");
    do_op(5'd12, 32'hFFFFFFFF, 32'h00000002, 0, "mulhu");
    do_op(5'd13, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
    do_op(5'd15, 32'h80000000, 32'hFFFFFFFF, 0, "rem_ovf");
    do_op(5'd14, 32'h00000007, 32'h00000000, 0, "divu_z");
    do_op(5'd16, 32'h00000007, 32'h00000000, 0, "remu_z");
    do_op(5'd13, 32'hFFFFFFF9, 32'h00000000, 0, "div_z");
    do_op(5'd15, 32'hFFFFFFF9, 32'h00000000, 0, "rem_z");
    do_op(5'd15, 32'hFFFFFFF9, 32'h00000002, 0, "rem_neg");
    do_op(5'd20, 32'h12345678, 32'h9ABCDEF0, 0, "undef");
    do_op(5'd10, 32'h12345678, 32'h9ABCDEF0, 10, "mul_hold");

    // Reset in the middle of a divide discards it
    @(negedge clk);
    in_valid   = 1'b1;
    srcA       = 32'd1000;
    srcB       = 32'd7;
    ALUControl = 5'd13;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("midbusy.busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("midbusy.ctl", {28'd0, in_ready, out_valid, busy, zero}, 32'h8);
    check_eq("midbusy.res", res, 32'd0);
    do_op(5'd1, 32'd5, 32'd7, 0, "sub_after_rst");

    for (int n = 0; n < 200; n++) begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 5'($urandom_range(0, 20));
      a  = pick_operand();
      b  = pick_operand();
      do_op(op, a, b, $urandom_range(0, 3), $sformatf("rnd%0d_op%0d", n, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
